drink_dispenser: RTL and testbench
==================================

DRINK_DISPENSER -- requirements
Module: drink_dispenser

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning the number of drink channels (2..16).
REQ-002 SHALL have parameter TIMEOUT, default 1000, meaning the maximum cycles spent in DISPENSE before the channel is declared faulted.
REQ-003 SHALL have parameter COOLDOWN, default 4, meaning the idle cycles enforced after each completed dispense (0 allowed).
REQ-004 SHALL have parameter CNT_W, default 8, meaning the width of each per-channel saturating dispense counter.
REQ-005 SHALL have port sclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port srst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port en, input, 1 bit: global enable; requests are accepted only while en=1.
REQ-008 SHALL have port req_valid, input, 1 bit: a dispense request is present.
REQ-009 SHALL have port req_ch, input, clog2(N_CH) bits: the requested channel index.
REQ-010 SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-011 SHALL have port drink_out_fin_n, input, N_CH bits: active-low per-channel dispense-finished sensors, asynchronous to sclk.
REQ-012 SHALL have port drink_control, output, N_CH bits: one-hot valve drive; all zero when no channel is dispensing.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port done_ok, output, 1 bit: qualifies done; 1 = success, 0 = fault or rejected request.
REQ-015 SHALL have port fault_mask, output, N_CH bits: sticky per-channel fault flags.
REQ-016 SHALL have port disp_cnt, output, N_CH*CNT_W bits: concatenated per-channel success counters, channel 0 in the LSBs.

Function
REQ-017 SHALL implement the FSM states IDLE, DISPENSE, REPORT, COOL.
REQ-018 SHALL drive req_ready=1 only in IDLE with en=1; a handshake is req_valid & req_ready in the same cycle.
REQ-019 SHALL, on a handshake to a channel with fault_mask[req_ch]=0 and req_ch<N_CH, latch the channel, go to DISPENSE next cycle, and assert drink_control[ch] from that cycle.
REQ-020 SHALL, on a handshake to a faulted or out-of-range channel, go to REPORT with done_ok=0 and never drive drink_control.
REQ-021 SHALL pass drink_out_fin_n through a 2-flop synchroniser and detect a falling edge on the synchronised value; a finish event is that edge on the active channel, visible 3 cycles after the input falls.
REQ-022 SHALL ignore a sensor already low at DISPENSE entry; only a new falling edge counts.
REQ-023 SHALL, on a finish event in DISPENSE, deassert drink_control the next cycle, enter REPORT with done_ok=1, and increment the channel counter, saturating at 2^CNT_W-1.
REQ-024 SHALL count DISPENSE cycles, and when the count reaches TIMEOUT with no finish event, set fault_mask[ch], deassert drink_control, and enter REPORT with done_ok=0.
REQ-025 SHALL treat a finish event in the same cycle as the timeout as success.
REQ-026 SHALL assert done for exactly the one REPORT cycle, then enter COOL for COOLDOWN cycles (skip COOL if COOLDOWN=0), then return to IDLE.
REQ-027 SHALL, if en drops during DISPENSE, abort: deassert drink_control next cycle and enter REPORT with done_ok=0, with no fault set and no counter change.
REQ-028 SHALL ignore finish edges on inactive channels.

Reset
REQ-029 SHALL, while srst=1 at a clock edge, set state IDLE; drink_control, done, done_ok, fault_mask and all counters to 0; synchroniser flops to all ones; timers to 0.
REQ-030 SHALL let srst override any state, including mid-DISPENSE, with the valve closed on the same edge.

Structure
REQ-031 SHALL place the FSM state enum and a clog2 helper function in the shared package vending_pkg.
REQ-032 SHALL implement the per-channel synchroniser plus falling-edge detector as the sub-module fin_edge_sync, instantiated N_CH times.

Verification
REQ-033 SHALL test a normal dispense: N_CH=4, request ch 2, fin_n[2] pulses low 20 cycles later -> drink_control=4'b0100 until 1 cycle after the detected edge, done=1 with done_ok=1, counter[2]=1.
REQ-034 SHALL test timeout: TIMEOUT=16, request ch 1, no fin -> drink_control[1] high for 16 cycles, done_ok=0, fault_mask=4'b0010; a later request to ch 1 -> done_ok=0 with no valve drive.
REQ-035 SHALL test a stale-low sensor: fin_n[0] held low before the request to ch 0 -> no completion until fin_n[0] rises and falls again.
REQ-036 SHALL test abort and reset: en=0 mid-DISPENSE -> done_ok=0 with fault_mask unchanged; srst=1 mid-DISPENSE -> drink_control=0 on the next edge and all outputs at reset values.
REQ-037 SHALL test saturation and back-pressure: CNT_W=2 with 5 successes on ch 3 -> counter=3; a request held during COOL -> req_ready=0 until exactly COOLDOWN cycles after done.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and helpers for the drink dispenser.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    REPORT   = 2'd2,
    COOL     = 2'd3
  } state_t;

  // Bits needed to index v items; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fin_edge_sync.sv
// Two-flop synchroniser for one active-low finish sensor plus falling-edge detect.
module fin_edge_sync (
  input  logic sclk,
  input  logic srst,
  input  logic fin_n,
  output logic fall_c
);

  // sh[0..1] synchronise, sh[2] holds the previous synchronised value
  logic [2:0] sh;

  always_ff @(posedge sclk) begin
    if (srst) sh <= '1;
    else      sh <= {sh[1:0], fin_n};
  end

  assign fall_c = sh[2] & ~sh[1];

endmodule

// File: rtl/drink_dispenser.sv
// Multi-channel drink dispenser: request handshake, valve drive, finish/timeout, cooldown.
module drink_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned COOLDOWN = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                        sclk,
  input  logic                        srst,
  input  logic                        en,
  input  logic                        req_valid,
  input  logic [clog2(N_CH)-1:0]      req_ch,
  output logic                        req_ready,
  input  logic [N_CH-1:0]             drink_out_fin_n,
  output logic [N_CH-1:0]             drink_control,
  output logic                        done,
  output logic                        done_ok,
  output logic [N_CH-1:0]             fault_mask,
  output logic [N_CH*CNT_W-1:0]       disp_cnt
);

  localparam int unsigned IDX_W   = clog2(N_CH);
  localparam int unsigned TMR_W   = clog2(TIMEOUT + 1);
  localparam int unsigned CL_W    = clog2(COOLDOWN + 1);
  localparam int unsigned CH_SPAN = 1 << IDX_W;
  // Index values that name a real channel
  localparam logic [CH_SPAN-1:0] CH_OK = CH_SPAN'((64'(1) << N_CH) - 64'(1));

  state_t               state;
  logic [IDX_W-1:0]     ch;
  logic [TMR_W-1:0]     timer;
  logic [CL_W-1:0]      cool;
  logic [CNT_W-1:0]     cnt [N_CH];
  logic [N_CH-1:0]      fin;
  logic [CH_SPAN-1:0]   fin_ext;
  logic [CH_SPAN-1:0]   fault_ext;
  logic                 hs;
  logic                 accept;

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    fin_edge_sync u_sync (
      .sclk   (sclk),
      .srst   (srst),
      .fin_n  (drink_out_fin_n[g]),
      .fall_c (fin[g])
    );
    assign disp_cnt[g*CNT_W +: CNT_W] = cnt[g];
  end

  assign fin_ext   = CH_SPAN'(fin);
  assign fault_ext = CH_SPAN'(fault_mask);
  assign req_ready = (state == IDLE) && en;
  assign hs        = req_valid && req_ready;
  assign accept    = CH_OK[req_ch] && !fault_ext[req_ch];

  always_ff @(posedge sclk) begin
    if (srst) begin
      state         <= IDLE;
      ch            <= '0;
      timer         <= '0;
      cool          <= '0;
      drink_control <= '0;
      done          <= 1'b0;
      done_ok       <= 1'b0;
      fault_mask    <= '0;
      for (int i = 0; i < int'(N_CH); i++) cnt[i] <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hs) begin
            if (accept) begin
              ch            <= req_ch;
              timer         <= '0;
              drink_control <= N_CH'(1) << req_ch;
              state         <= DISPENSE;
            end else begin
              done    <= 1'b1;
              done_ok <= 1'b0;
              state   <= REPORT;
            end
          end
        end
        DISPENSE: begin
          timer <= timer + TMR_W'(1);
          // Abort first, then finish (wins over a simultaneous timeout), then timeout
          if (!en) begin
            drink_control <= '0;
            done          <= 1'b1;
            done_ok       <= 1'b0;
            state         <= REPORT;
          end else if (fin_ext[ch]) begin
            drink_control <= '0;
            done          <= 1'b1;
            done_ok       <= 1'b1;
            if (cnt[ch] != '1) cnt[ch] <= cnt[ch] + CNT_W'(1);
            state         <= REPORT;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            drink_control  <= '0;
            fault_mask[ch] <= 1'b1;
            done           <= 1'b1;
            done_ok        <= 1'b0;
            state          <= REPORT;
          end
        end
        REPORT: begin
          done_ok <= 1'b0;
          cool    <= '0;
          state   <= (COOLDOWN == 0) ? IDLE : COOL;
        end
        COOL: begin
          if (cool == CL_W'(COOLDOWN - 1)) state <= IDLE;
          else                             cool  <= cool + CL_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drink_dispenser.sv
// Scoreboard bench for drink_dispenser: directed requests, expected completions queued.
module tb_drink_dispenser;

  typedef struct {
    logic       ok;
    logic [3:0] fmask;
    logic [7:0] cnt;
  } exp_t;

  logic       sclk;
  logic       srst;
  logic       en;
  logic       req_valid;
  logic [1:0] req_ch;
  logic       req_ready;
  logic [3:0] fin_n;
  logic [3:0] drink_control;
  logic       done;
  logic       done_ok;
  logic [3:0] fault_mask;
  logic [7:0] disp_cnt;

  int   n_vec;
  int   n_err;
  exp_t exp_q[$];

  drink_dispenser #(
    .N_CH(4), .TIMEOUT(16), .COOLDOWN(4), .CNT_W(2)
  ) dut (
    .sclk            (sclk),
    .srst            (srst),
    .en              (en),
    .req_valid       (req_valid),
    .req_ch          (req_ch),
    .req_ready       (req_ready),
    .drink_out_fin_n (fin_n),
    .drink_control   (drink_control),
    .done            (done),
    .done_ok         (done_ok),
    .fault_mask      (fault_mask),
    .disp_cnt        (disp_cnt)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic push(input logic ok, input logic [3:0] fm, input logic [7:0] c);
    exp_t e;
    e.ok = ok; e.fmask = fm; e.cnt = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse pops one expected completion
  always @(negedge sclk) begin
    if (!srst && done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_ok", 32'(done_ok), 32'(e.ok));
        check("fault_mask", 32'(fault_mask), 32'(e.fmask));
        check("disp_cnt", 32'(disp_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic do_req(input logic [1:0] c);
    wait_ready();
    req_valid = 1'b1;
    req_ch    = c;
    tick();
    req_valid = 1'b0;
  endtask

  // Sensor falls after pre cycles in DISPENSE; valve closes on the third edge after
  task automatic dispense_ok(input logic [1:0] c, input int pre, input logic [7:0] ecnt,
                             input logic [3:0] efm);
    logic [3:0] oh;
    oh = 4'd1 << c;
    do_req(c);
    check("valve_on", 32'(drink_control), 32'(oh));
    repeat (pre) tick();
    push(1'b1, efm, ecnt);
    fin_n[c] = 1'b0;
    tick();
    check("valve_hold1", 32'(drink_control), 32'(oh));
    tick();
    check("valve_hold2", 32'(drink_control), 32'(oh));
    tick();
    check("valve_off", 32'(drink_control), 32'd0);
    fin_n[c] = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    srst = 1'b1; en = 1'b1; req_valid = 1'b0; req_ch = 2'd0; fin_n = 4'hF;
    repeat (3) @(posedge sclk);
    #1;
    check("rst_valve", 32'(drink_control), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault_mask), 32'd0);
    check("rst_cnt", 32'(disp_cnt), 32'd0);
    srst = 1'b0;
    tick();
    check("rst_ready", 32'(req_ready), 32'd1);

    // Normal dispense on channel 2
    dispense_ok(2'd2, 8, 8'h10, 4'h0);

    // Timeout on channel 1: valve high for exactly 16 cycles
    do_req(2'd1);
    push(1'b0, 4'b0010, 8'h10);
    for (int i = 0; i < 16; i++) begin
      check("to_valve_on", 32'(drink_control), 32'b0010);
      tick();
    end
    check("to_valve_off", 32'(drink_control), 32'd0);
    push(1'b0, 4'b0010, 8'h10);
    do_req(2'd1);
    check("faulted_no_valve", 32'(drink_control), 32'd0);

    // Stale-low sensor on channel 0
    fin_n[0] = 1'b0;
    repeat (4) tick();
    do_req(2'd0);
    repeat (6) tick();
    check("stale_valve", 32'(drink_control), 32'b0001);
    fin_n[0] = 1'b1;
    repeat (3) tick();
    push(1'b1, 4'b0010, 8'h11);
    fin_n[0] = 1'b0;
    repeat (2) tick();
    check("stale_hold", 32'(drink_control), 32'b0001);
    tick();
    check("stale_off", 32'(drink_control), 32'd0);
    fin_n[0] = 1'b1;

    // Abort by dropping en mid-dispense on channel 3
    do_req(2'd3);
    repeat (3) tick();
    push(1'b0, 4'b0010, 8'h11);
    en = 1'b0;
    tick();
    check("abort_valve", 32'(drink_control), 32'd0);
    en = 1'b1;

    // Five successes on channel 3; first coincides with the timeout cycle
    dispense_ok(2'd3, 13, 8'h51, 4'b0010);
    dispense_ok(2'd3, 5, 8'h91, 4'b0010);
    dispense_ok(2'd3, 5, 8'hD1, 4'b0010);
    dispense_ok(2'd3, 5, 8'hD1, 4'b0010);
    dispense_ok(2'd3, 5, 8'hD1, 4'b0010);

    // Request held from the done cycle: blocked through the 4 cooldown cycles
    req_valid = 1'b1;
    req_ch    = 2'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cool_not_ready", 32'(req_ready), 32'd0);
    end
    tick();
    check("cool_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("held_req_valve", 32'(drink_control), 32'b0100);

    // Reset mid-dispense
    repeat (2) tick();
    srst = 1'b1;
    tick();
    check("srst_valve", 32'(drink_control), 32'd0);
    check("srst_done", 32'(done), 32'd0);
    check("srst_ok", 32'(done_ok), 32'd0);
    check("srst_fault", 32'(fault_mask), 32'd0);
    check("srst_cnt", 32'(disp_cnt), 32'd0);
    srst = 1'b0;
    tick();
    check("srst_ready", 32'(req_ready), 32'd1);
    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
